// File: rtl/jstk_xfer_sched.sv
// Frame scheduler for the PmodJSTK SPI engine. It arbitrates between periodic position polls
// and on-demand RGB updates, enforces an inter-frame gap and times out lost responses.
module jstk_xfer_sched #(
  parameter int unsigned POLL_CYCLES    = 120000,
  parameter int unsigned GAP_CYCLES     = 120,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  LED_CMD        = 8'h84,
  parameter logic [7:0]  POLL_CMD       = 8'hC0
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        color_valid_i,
  output logic        color_ready_o,
  input  logic [23:0] color_rgb_i,
  output logic        xfer_valid_o,
  input  logic        xfer_ready_i,
  output logic [39:0] xfer_data_o,
  input  logic        rsp_valid_i,
  input  logic [39:0] rsp_data_i,
  output logic        sample_valid_o,
  output logic [9:0]  position_x_o,
  output logic [9:0]  position_y_o,
  output logic [1:0]  buttons_o,
  output logic        timeout_o,
  output logic [7:0]  err_count_o
);

  localparam int unsigned PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    GAP
  } state_t;

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          poll_pending;
  logic          color_pending;
  logic [23:0]   color_rgb;
  logic          last_grant_led;
  logic          poll_tick;
  logic          color_acc;
  logic          pick_led;

  always_comb begin
    poll_tick     = (poll_cnt == POLL_LAST);
    color_ready_o = !color_pending;
    color_acc     = color_valid_i && !color_pending;
    // With both requests pending, the source not served last time wins.
    pick_led      = color_pending && !(poll_pending && last_grant_led);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      poll_cnt <= '0;
    end else if (poll_tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state          <= IDLE;
      gap_cnt        <= '0;
      tmo_cnt        <= '0;
      poll_pending   <= 1'b0;
      color_pending  <= 1'b0;
      color_rgb      <= '0;
      last_grant_led <= 1'b0;
      xfer_valid_o   <= 1'b0;
      xfer_data_o    <= '0;
      sample_valid_o <= 1'b0;
      position_x_o   <= '0;
      position_y_o   <= '0;
      buttons_o      <= '0;
      timeout_o      <= 1'b0;
      err_count_o    <= '0;
    end else begin
      sample_valid_o <= 1'b0;
      timeout_o      <= 1'b0;

      if (color_acc) begin
        color_pending <= 1'b1;
        color_rgb     <= color_rgb_i;
      end

      case (state)
        IDLE: begin
          if (poll_pending || color_pending) begin
            last_grant_led <= pick_led;
            xfer_data_o    <= pick_led ? {LED_CMD, color_rgb, 8'h00} : {POLL_CMD, 32'h0};
            xfer_valid_o   <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (xfer_ready_i) begin
            xfer_valid_o <= 1'b0;
            if (last_grant_led) begin
              color_pending <= 1'b0;
            end else begin
              poll_pending <= 1'b0;
            end
            tmo_cnt <= '0;
            state   <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_valid_i) begin
            position_x_o   <= {rsp_data_i[9:8], rsp_data_i[23:16]};
            position_y_o   <= {rsp_data_i[25:24], rsp_data_i[39:32]};
            buttons_o      <= rsp_data_i[1:0];
            sample_valid_o <= 1'b1;
            gap_cnt        <= '0;
            state          <= GAP;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_o <= 1'b1;
            if (err_count_o != 8'hFF) begin
              err_count_o <= err_count_o + 1'b1;
            end
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A poll tick coinciding with acceptance of the previous poll re-arms the request.
      if (poll_tick) begin
        poll_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jstk_xfer_sched.sv
// Randomized bench for jstk_xfer_sched against a timestamp-based reference of the frame schedule.
module tb_jstk_xfer_sched;

  localparam int P = 50;
  localparam int G = 4;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        color_valid;
  logic        color_ready;
  logic [23:0] color_rgb;
  logic        xfer_valid;
  logic        xfer_ready;
  logic [39:0] xfer_data;
  logic        rsp_valid;
  logic [39:0] rsp_data;
  logic        sample_valid;
  logic [9:0]  position_x;
  logic [9:0]  position_y;
  logic [1:0]  buttons;
  logic        timeout;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  jstk_xfer_sched #(
    .POLL_CYCLES(P),
    .GAP_CYCLES(G),
    .TIMEOUT_CYCLES(T),
    .LED_CMD(8'h84),
    .POLL_CMD(8'hC0)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .color_valid_i(color_valid),
    .color_ready_o(color_ready),
    .color_rgb_i(color_rgb),
    .xfer_valid_o(xfer_valid),
    .xfer_ready_i(xfer_ready),
    .xfer_data_o(xfer_data),
    .rsp_valid_i(rsp_valid),
    .rsp_data_i(rsp_data),
    .sample_valid_o(sample_valid),
    .position_x_o(position_x),
    .position_y_o(position_y),
    .buttons_o(buttons),
    .timeout_o(timeout),
    .err_count_o(err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs
  int          k_col   = 0;
  int          k_ready = 100;
  int          k_rsp   = 0;
  int          k_lat   = -1;
  logic        rgb_fix_en = 1'b0;
  logic [23:0] rgb_fix    = '0;
  logic        rsp_fix_en = 1'b0;
  logic [39:0] rsp_fix    = '0;

  // Reference: edge index since reset release, pending requests, and the timestamps of the
  // frame in flight (accept edge) and of the earliest edge the arbiter may grant again.
  int          n;
  int          m_a;
  int          m_free;
  logic        m_pp, m_cp, m_last_led, m_outst, m_acc;
  logic [23:0] m_rgb;
  logic        m_valid, m_sv, m_to;
  logic [39:0] m_data;
  logic [9:0]  m_x, m_y;
  logic [1:0]  m_btn;
  logic [7:0]  m_err;

  function automatic logic [39:0] mk_rsp(input logic [9:0] x, input logic [9:0] y,
                                         input logic [1:0] b);
    logic [39:0] r;
    r = '0;
    r[23:16] = x[7:0];
    r[9:8]   = x[9:8];
    r[39:32] = y[7:0];
    r[25:24] = y[9:8];
    r[1:0]   = b;
    return r;
  endfunction

  task automatic model_reset();
    n = 0; m_a = 0; m_free = 0;
    m_pp = 0; m_cp = 0; m_last_led = 0; m_outst = 0; m_acc = 0;
    m_rgb = '0; m_valid = 0; m_sv = 0; m_to = 0; m_data = '0;
    m_x = '0; m_y = '0; m_btn = '0; m_err = '0;
  endtask

  task automatic model_edge();
    logic cp0, led;
    cp0  = m_cp;
    m_sv = 0;
    m_to = 0;
    if (!m_outst) begin
      if (n >= m_free && (m_pp || m_cp)) begin
        led        = m_cp && !(m_pp && m_last_led);
        m_last_led = led;
        m_data     = led ? {8'h84, m_rgb, 8'h00} : {8'hC0, 32'h0};
        m_valid    = 1;
        m_outst    = 1;
        m_acc      = 0;
      end
    end else if (!m_acc) begin
      if (xfer_ready) begin
        m_acc   = 1;
        m_a     = n;
        m_valid = 0;
        if (m_last_led) m_cp = 0;
        else            m_pp = 0;
      end
    end else if (rsp_valid) begin
      m_x     = {rsp_data[9:8], rsp_data[23:16]};
      m_y     = {rsp_data[25:24], rsp_data[39:32]};
      m_btn   = rsp_data[1:0];
      m_sv    = 1;
      m_outst = 0;
      m_free  = n + G + 1;
    end else if (n == m_a + T) begin
      m_to    = 1;
      if (m_err != 8'd255) m_err = m_err + 8'd1;
      m_outst = 0;
      m_free  = n + G + 1;
    end
    if (color_valid && !cp0) begin
      m_cp  = 1;
      m_rgb = color_rgb;
    end
    if (n % P == P - 1) m_pp = 1;
    n++;
  endtask

  task automatic step();
    logic [63:0] r;
    color_valid = ($urandom_range(99) < k_col);
    color_rgb   = rgb_fix_en ? rgb_fix : 24'($urandom);
    xfer_ready  = ($urandom_range(99) < k_ready);
    r           = {$urandom, $urandom};
    rsp_data    = rsp_fix_en ? rsp_fix : r[39:0];
    if (k_lat >= 0) rsp_valid = m_outst && m_acc && (n == m_a + k_lat);
    else            rsp_valid = ($urandom_range(99) < k_rsp);
    if (!reset_n) model_reset();
    else          model_edge();
    @(posedge clk);
    #1;
    check_eq("xfer_valid", 64'(xfer_valid), 64'(m_valid));
    if (m_valid) check_eq("xfer_data", 64'(xfer_data), 64'(m_data));
    check_eq("color_ready", 64'(color_ready), 64'(!m_cp));
    check_eq("sample_valid", 64'(sample_valid), 64'(m_sv));
    check_eq("position_x", 64'(position_x), 64'(m_x));
    check_eq("position_y", 64'(position_y), 64'(m_y));
    check_eq("buttons", 64'(buttons), 64'(m_btn));
    check_eq("timeout", 64'(timeout), 64'(m_to));
    check_eq("err_count", 64'(err_count), 64'(m_err));
  endtask

  initial begin
    reset_n     = 1'b0;
    color_valid = 1'b0;
    color_rgb   = '0;
    xfer_ready  = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    model_reset();
    repeat (3) step();
    check_eq("rst_data", 64'(xfer_data), 64'h0);
    check_eq("rst_color_ready", 64'(color_ready), 64'h1);
    reset_n = 1'b1;

    // Poll-only traffic, response three cycles after acceptance with a fixed sample
    k_col = 0; k_ready = 100; k_lat = 3;
    rsp_fix_en = 1'b1; rsp_fix = mk_rsp(10'h2A5, 10'h155, 2'b10);
    repeat (150) step();
    check_eq("poll_x", 64'(position_x), 64'h2A5);
    check_eq("poll_y", 64'(position_y), 64'h155);
    check_eq("poll_btn", 64'(buttons), 64'h2);
    rsp_fix_en = 1'b0;

    // Single colour update held off by the engine for several cycles
    rgb_fix_en = 1'b1; rgb_fix = 24'hFF0000;
    k_col = 100; k_ready = 0;
    step();
    k_col = 0;
    repeat (7) step();
    k_ready = 100;
    repeat (20) step();
    rgb_fix_en = 1'b0;

    // Continuous colour traffic competing with polls
    k_col = 100; k_ready = 100; k_lat = 3;
    repeat (300) step();

    // No responses at all: every frame times out until the counter saturates
    k_lat = -1; k_rsp = 0;
    repeat (7000) step();
    check_eq("err_saturated", 64'(err_count), 64'd255);

    // Reset while waiting for a response, with responses during and after reset
    k_col = 100;
    step();
    k_col = 0;
    for (int i = 0; i < 200 && !(m_outst && m_acc && n > m_a + 2); i++) step();
    check_eq("reach_wait_rsp", 64'(m_outst && m_acc), 64'h1);
    reset_n = 1'b0; k_rsp = 100;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();
    k_rsp = 0;
    check_eq("rst_pos_x", 64'(position_x), 64'h0);
    check_eq("rst_sample", 64'(sample_valid), 64'h0);
    check_eq("rst_ready", 64'(color_ready), 64'h1);
    check_eq("rst_xfer_valid", 64'(xfer_valid), 64'h0);
    check_eq("rst_err", 64'(err_count), 64'h0);

    // Mixed random traffic, including stray responses outside the wait window
    k_col = 30; k_ready = 60; k_rsp = 15; k_lat = -1;
    repeat (3000) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
